// File: rtl/bp_me_xlate_pkg.sv
// Cord-to-ID translation types, region constants and helper functions.
// Shared by the cord translation scheduler and its testbench-facing top.
package bp_me_xlate_pkg;

  localparam int cord_w = 5;
  localparam int core_w = 2;
  localparam int cce_w  = 4;
  localparam int lce_w  = 6;

  localparam int cc_y_min = 1;
  localparam int cc_y_max = 3;
  localparam int mc_y_min = 4;
  localparam int ac_x     = 3;

  typedef enum logic [1:0] {
    e_cc,
    e_mc,
    e_ac,
    e_io
  } cord_region_e;

  typedef struct packed {
    logic [core_w-1:0] core;
    logic [cce_w-1:0]  cce;
    logic [lce_w-1:0]  lce0;
    logic [lce_w-1:0]  lce1;
  } xlate_ids_s;

  function automatic cord_region_e cord_region(
    input logic [cord_w-1:0] cord
  );
    logic [1:0] x;
    logic [2:0] y;
    logic       y_cc;
    cord_region_e r;
    x    = cord[1:0];
    y    = cord[4:2];
    y_cc = (y >= 3'(cc_y_min)) && (y <= 3'(cc_y_max));
    unique case (1'b1)
      (x != 2'(ac_x)) && y_cc:                r = e_cc;
      (x != 2'(ac_x)) && (y >= 3'(mc_y_min)): r = e_mc;
      (x == 2'(ac_x)) && y_cc:                r = e_ac;
      default:                                r = e_io;
    endcase
    return r;
  endfunction

  function automatic xlate_ids_s cord_to_ids(
    input logic [cord_w-1:0] cord
  );
    logic [1:0]       x;
    logic [2:0]       ym1;
    logic [cce_w-1:0] cce;
    logic [lce_w-1:0] lce0;
    xlate_ids_s       ids;
    x   = cord[1:0];
    ym1 = cord[4:2] - 3'd1;
    unique case (cord_region(cord))
      e_cc: begin
        cce  = {2'b00, x} + {ym1, 1'b0};
        lce0 = {1'b0, cce, 1'b0};
      end
      e_ac: begin
        cce  = 4'd4 + {1'b0, ym1};
        lce0 = 6'd8 + {{3{ym1[2]}}, ym1};
      end
      default: begin
        cce  = 4'd4 + {2'b00, x};
        lce0 = 6'd8 + {4'b0000, x};
      end
    endcase
    ids.core = cce[1:0];
    ids.cce  = cce;
    ids.lce0 = lce0;
    ids.lce1 = {3'b000, cce[1:0], 1'b1};
    return ids;
  endfunction

endpackage

// File: rtl/bp_me_cord_xlate_sched_if.sv
// Request/response bundle of the cord translation scheduler.
// master: requesters + consumer side; slave: the scheduler. resp_err_o only with BP_ME_XLATE_ERR_EN.
interface bp_me_cord_xlate_sched_if #(
  parameter int num_req_p       = 4,
  parameter int cord_width_p    = 5,
  parameter int core_id_width_p = 2,
  parameter int cce_id_width_p  = 4,
  parameter int lce_id_width_p  = 6
);
  localparam int tag_w = $clog2(num_req_p);

  logic [num_req_p-1:0]              req_v_i;
  logic [num_req_p*cord_width_p-1:0] req_cord_i;
  logic [num_req_p-1:0]              req_yumi_o;
  logic                              resp_v_o;
  logic [tag_w-1:0]                  resp_tag_o;
  logic [core_id_width_p-1:0]        resp_core_id_o;
  logic [cce_id_width_p-1:0]         resp_cce_id_o;
  logic [lce_id_width_p-1:0]         resp_lce_id0_o;
  logic [lce_id_width_p-1:0]         resp_lce_id1_o;
  logic                              resp_yumi_i;
`ifdef BP_ME_XLATE_ERR_EN
  logic                              resp_err_o;
`endif

  modport master (
    output req_v_i, req_cord_i, resp_yumi_i,
    input  req_yumi_o, resp_v_o, resp_tag_o,
    input  resp_core_id_o, resp_cce_id_o,
    input  resp_lce_id0_o, resp_lce_id1_o
`ifdef BP_ME_XLATE_ERR_EN
    , input resp_err_o
`endif
  );

  modport slave (
    input  req_v_i, req_cord_i, resp_yumi_i,
    output req_yumi_o, resp_v_o, resp_tag_o,
    output resp_core_id_o, resp_cce_id_o,
    output resp_lce_id0_o, resp_lce_id1_o
`ifdef BP_ME_XLATE_ERR_EN
    , output resp_err_o
`endif
  );

endinterface

// File: rtl/bp_me_xlate_rr_arb.sv
// Round-robin arbiter: grants the first valid requester at or after rr_ptr.
// Ports: v_i requests, en_i grant enable, grant_o one-hot, tag_o winner index.
module bp_me_xlate_rr_arb #(
  parameter  int num_req_p = 4,
  localparam int tag_w     = $clog2(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_req_p-1:0] v_i,
  input  logic                 en_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [tag_w-1:0]     tag_o
);

  logic [tag_w-1:0] rr_ptr_q, rr_ptr_d;
  logic [tag_w:0]   idx;
  logic             found;

  always_comb begin
    found    = 1'b0;
    tag_o    = '0;
    idx      = '0;
    grant_o  = '0;
    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < num_req_p; i++) begin
      idx = {1'b0, rr_ptr_q} + (tag_w+1)'(i);
      if (idx >= (tag_w+1)'(num_req_p))
        idx = idx - (tag_w+1)'(num_req_p);
      if (!found && v_i[idx[tag_w-1:0]]) begin
        found = 1'b1;
        tag_o = idx[tag_w-1:0];
      end
    end
    if (en_i && found) begin
      grant_o[tag_o] = 1'b1;
      rr_ptr_d = (tag_o == tag_w'(num_req_p-1))
               ? '0 : tag_o + tag_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/bp_me_cord_xlate_sched.sv
// Shared cord-to-ID translator: RR grant into S1, translate into S2, S2 drives resp_*.
// Ports: clk_i, reset_i (sync, active-high), io (slave). BP_ME_XLATE_ERR_EN adds resp_err_o.
module bp_me_cord_xlate_sched
  import bp_me_xlate_pkg::*;
#(
  parameter int num_req_p       = 4,
  parameter int cord_width_p    = cord_w,
  parameter int core_id_width_p = core_w,
  parameter int cce_id_width_p  = cce_w,
  parameter int lce_id_width_p  = lce_w
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bp_me_cord_xlate_sched_if.slave io
);

  localparam int tag_w = $clog2(num_req_p);

  logic                    s1_v_q, s1_v_d;
  logic [cord_width_p-1:0] s1_cord_q, s1_cord_d;
  logic [tag_w-1:0]        s1_tag_q, s1_tag_d;
  logic                    s2_v_q, s2_v_d;
  logic [tag_w-1:0]        s2_tag_q, s2_tag_d;
  xlate_ids_s              s2_ids_q, s2_ids_d;
  logic                    s2_err_q, s2_err_d;

  logic                    s2_free, s1_adv, s1_free;
  logic [num_req_p-1:0]    grant;
  logic [tag_w-1:0]        gtag;
  logic [cord_width_p-1:0] gcord;
  logic [cord_w-1:0]       s1_cord;

  assign s2_free = !s2_v_q | io.resp_yumi_i;
  assign s1_adv  = s1_v_q & s2_free;
  assign s1_free = !s1_v_q | s1_adv;
  assign s1_cord = cord_w'(s1_cord_q);

  bp_me_xlate_rr_arb #(
    .num_req_p(num_req_p)
  ) arb (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (io.req_v_i),
    .en_i   (s1_free & !reset_i),
    .grant_o(grant),
    .tag_o  (gtag)
  );

  assign gcord = io.req_cord_i[int'(gtag)*cord_width_p +: cord_width_p];

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_cord_d = s1_cord_q;
    s1_tag_d  = s1_tag_q;
    if (|grant) begin
      s1_v_d    = 1'b1;
      s1_cord_d = gcord;
      s1_tag_d  = gtag;
    end else if (s1_adv) begin
      s1_v_d = 1'b0;
    end
    s2_v_d   = s2_v_q;
    s2_tag_d = s2_tag_q;
    s2_ids_d = s2_ids_q;
    s2_err_d = s2_err_q;
    if (s1_adv) begin
      s2_v_d   = 1'b1;
      s2_tag_d = s1_tag_q;
      s2_ids_d = cord_to_ids(s1_cord);
      s2_err_d = (cord_region(s1_cord) == e_io);
    end else if (io.resp_yumi_i) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_v_q    <= 1'b0;
      s1_cord_q <= '0;
      s1_tag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_tag_q  <= '0;
      s2_ids_q  <= '0;
      s2_err_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_cord_q <= s1_cord_d;
      s1_tag_q  <= s1_tag_d;
      s2_v_q    <= s2_v_d;
      s2_tag_q  <= s2_tag_d;
      s2_ids_q  <= s2_ids_d;
      s2_err_q  <= s2_err_d;
    end
  end

  assign io.req_yumi_o     = grant;
  assign io.resp_v_o       = s2_v_q;
  assign io.resp_tag_o     = s2_tag_q;
  assign io.resp_core_id_o = core_id_width_p'(s2_ids_q.core);
  assign io.resp_cce_id_o  = cce_id_width_p'(s2_ids_q.cce);
  assign io.resp_lce_id0_o = lce_id_width_p'(s2_ids_q.lce0);
  assign io.resp_lce_id1_o = lce_id_width_p'(s2_ids_q.lce1);
`ifdef BP_ME_XLATE_ERR_EN
  assign io.resp_err_o     = s2_err_q;
`else
  logic unused_err;
  assign unused_err = s2_err_q;
`endif

endmodule

// File: tb/tb_bp_me_cord_xlate_sched.sv
// Testbench for bp_me_cord_xlate_sched: queue-based model plus directed cases.
// Honours BP_ME_XLATE_ERR_EN for the resp_err_o checks.
module tb_bp_me_cord_xlate_sched;

  localparam int N  = 4;
  localparam int CW = 5;
  localparam int TW = 2;

  bit clk     = 1'b0;
  bit reset_i = 1'b1;
  bit ryumi_en = 1'b0;
  int n_chk  = 0;
  int n_fail = 0;

  bp_me_cord_xlate_sched_if #(
    .num_req_p(N), .cord_width_p(CW),
    .core_id_width_p(2), .cce_id_width_p(4),
    .lce_id_width_p(6)
  ) bus ();

  bp_me_cord_xlate_sched #(
    .num_req_p(N), .cord_width_p(CW),
    .core_id_width_p(2), .cce_id_width_p(4),
    .lce_id_width_p(6)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .io     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Region rules written directly from the cord map.
  task automatic model(input logic [4:0] c,
                       output int core, output int cce,
                       output int lce0, output int lce1,
                       output int err);
    int x, y;
    x = int'(c[1:0]);
    y = int'(c[4:2]);
    err = 0;
    if (x <= 2 && y >= 1 && y <= 3) begin
      cce = x + 2 * (y - 1); lce0 = 2 * cce;
    end else if (x <= 2 && y >= 4) begin
      cce = 4 + x; lce0 = 8 + x;
    end else if (x == 3 && y >= 1 && y <= 3) begin
      cce = 4 + (y - 1); lce0 = 8 + (y - 1);
    end else begin
      cce = 4 + x; lce0 = 8 + x; err = 1;
    end
    core = cce % 4;
    lce1 = 2 * core + 1;
  endtask

  int         q_tag[$];
  logic [4:0] q_cord[$];
  int         q_cyc[$];
  int         gseq[$];
  int         cyc = 0;
  int         mrr = 0;
  bit         rst_prev = 1'b0;

  always @(negedge clk) begin
    int eg, m_core, m_cce, m_lce0, m_lce1, m_err;
    logic [N-1:0] ey;
    bit erv;
    if (rst_prev) begin
      chk("rst_resp_v", 32'(bus.resp_v_o), 0);
      chk("rst_data", 32'({bus.resp_tag_o, bus.resp_core_id_o,
          bus.resp_cce_id_o, bus.resp_lce_id0_o,
          bus.resp_lce_id1_o}), 0);
    end
    if (reset_i) begin
      chk("rst_yumi", 32'(bus.req_yumi_o), 0);
      q_tag.delete(); q_cord.delete(); q_cyc.delete();
      mrr = 0;
    end else begin
      eg = -1;
      if (bus.req_v_i != '0 &&
          (q_tag.size() < 2 || bus.resp_yumi_i))
        for (int k = 0; k < N; k++)
          if (eg < 0 && bus.req_v_i[(mrr + k) % N])
            eg = (mrr + k) % N;
      ey = '0;
      if (eg >= 0) ey[eg] = 1'b1;
      chk("grant", 32'(bus.req_yumi_o), 32'(ey));
      for (int k = 0; k < N; k++)
        if (bus.req_yumi_o[k]) gseq.push_back(k);
      erv = q_tag.size() > 0 && q_cyc[0] <= cyc - 2;
      chk("resp_v", 32'(bus.resp_v_o), 32'(erv));
      if (bus.resp_v_o && erv) begin
        model(q_cord[0], m_core, m_cce, m_lce0, m_lce1, m_err);
        chk("resp_tag", 32'(bus.resp_tag_o), q_tag[0]);
        chk("resp_core", 32'(bus.resp_core_id_o), m_core);
        chk("resp_cce", 32'(bus.resp_cce_id_o), m_cce);
        chk("resp_lce0", 32'(bus.resp_lce_id0_o), m_lce0);
        chk("resp_lce1", 32'(bus.resp_lce_id1_o), m_lce1);
`ifdef BP_ME_XLATE_ERR_EN
        chk("resp_err", 32'(bus.resp_err_o), m_err);
`endif
      end
      if (bus.resp_v_o && bus.resp_yumi_i && q_tag.size() > 0) begin
        void'(q_tag.pop_front());
        void'(q_cord.pop_front());
        void'(q_cyc.pop_front());
      end
      if (eg >= 0) begin
        q_tag.push_back(eg);
        q_cord.push_back(bus.req_cord_i[eg*CW +: CW]);
        q_cyc.push_back(cyc);
        mrr = (eg + 1) % N;
      end
    end
    rst_prev = reset_i;
    cyc++;
  end

  always @(posedge clk) begin
    #2;
    bus.resp_yumi_i = ryumi_en & bus.resp_v_o & !reset_i;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int idx, input logic [4:0] cord,
                        input int e_core, input int e_cce,
                        input int e_lce0, input int e_lce1,
                        input int e_err);
    int k;
    bus.req_cord_i[idx*CW +: CW] = cord;
    bus.req_v_i = '0;
    bus.req_v_i[idx] = 1'b1;
    ryumi_en = 1'b1;
    step();
    bus.req_v_i = '0;
    k = 0;
    while (!bus.resp_v_o && k < 8) begin
      step();
      k++;
    end
    chk("latency", k + 1, 2);
    if (bus.resp_v_o) begin
      chk("lit_tag", 32'(bus.resp_tag_o), idx);
      chk("lit_core", 32'(bus.resp_core_id_o), e_core);
      chk("lit_cce", 32'(bus.resp_cce_id_o), e_cce);
      chk("lit_lce0", 32'(bus.resp_lce_id0_o), e_lce0);
      chk("lit_lce1", 32'(bus.resp_lce_id1_o), e_lce1);
`ifdef BP_ME_XLATE_ERR_EN
      chk("lit_err", 32'(bus.resp_err_o), e_err);
`else
      if (e_err > 1) chk("lit_err", e_err, 0);
`endif
    end
    step();
  endtask

  initial begin
    logic [31:0] held;
    bus.req_v_i    = '0;
    bus.req_cord_i = '0;
    repeat (2) step();
    reset_i = 1'b0;

    // back-to-back round robin
    ryumi_en = 1'b1;
    gseq.delete();
    bus.req_cord_i = {5'b01111, 5'b10010, 5'b00101, 5'b01001};
    bus.req_v_i = '1;
    repeat (5) step();
    bus.req_v_i = '0;
    repeat (4) step();
    chk("rr_count", gseq.size(), 5);
    for (int i = 0; i < 5 && i < gseq.size(); i++)
      chk($sformatf("rr_order%0d", i), gseq[i], i % 4);

    // single requests and region corners
    single(0, {3'd2, 2'd1}, 3, 3, 6, 7, 0);
    single(1, {3'd1, 2'd0}, 0, 0, 0, 1, 0);
    single(2, {3'd4, 2'd2}, 2, 6, 10, 5, 0);
    single(3, {3'd3, 2'd3}, 2, 6, 10, 5, 0);
    single(1, {3'd0, 2'd1}, 1, 5, 9, 3, 1);

    // consumer stall
    ryumi_en = 1'b0;
    gseq.delete();
    bus.req_v_i = '1;
    repeat (3) step();
    held = 32'({bus.resp_tag_o, bus.resp_core_id_o,
                bus.resp_cce_id_o, bus.resp_lce_id0_o,
                bus.resp_lce_id1_o});
    chk("stall_tag", 32'(bus.resp_tag_o), 2);
    repeat (2) step();
    chk("stall_grants", gseq.size(), 2);
    chk("stall_hold", 32'({bus.resp_tag_o, bus.resp_core_id_o,
        bus.resp_cce_id_o, bus.resp_lce_id0_o,
        bus.resp_lce_id1_o}), held);
    bus.req_v_i = '0;
    ryumi_en = 1'b1;
    repeat (5) step();
    chk("stall_drain", q_tag.size(), 0);

    // reset with both stages full
    ryumi_en = 1'b0;
    bus.req_v_i = '1;
    repeat (3) step();
    chk("full_resp_v", 32'(bus.resp_v_o), 1);
    reset_i = 1'b1;
    bus.req_v_i = 4'b0110;
    gseq.delete();
    repeat (2) step();
    reset_i = 1'b0;
    chk("post_rst_resp_v", 32'(bus.resp_v_o), 0);
    step();
    chk("post_rst_first", gseq.size() > 0 ? gseq[0] : -1, 1);
    bus.req_v_i = '0;
    ryumi_en = 1'b1;
    repeat (5) step();
    chk("rst_drain", q_tag.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
